// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with scoreboard busy bits, write bypass and busy counter
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_iss;
    logic             w_inc;
    logic             w_dec;

    // x0 is never a target; a write held during reset must not leak through the bypass
    assign w_wr  = we && rst_n && (wr_addr != '0);
    assign w_iss = iss_valid && (iss_rd != '0) && !flush;
    assign w_inc = w_iss && !r_busy[iss_rd];
    assign w_dec = w_wr && r_busy[wr_addr] && !(w_iss && (iss_rd == wr_addr));
    assign busy_cnt = r_cnt;

    // register data; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // busy bits: writeback clears, issue sets afterwards so issue wins on a collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            if (w_wr) r_busy[wr_addr] <= 1'b0;
            if (w_iss) r_busy[iss_rd] <= 1'b1;
        end
    end

    // popcount of busy tracked incrementally; only real 0->1 / 1->0 transitions count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    // combinational reads with optional same-cycle write forwarding
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        rs1_busy = r_busy[rs1_addr];
        rs2_data = r_regs[rs2_addr];
        rs2_busy = r_busy[rs2_addr];
        if (BYPASS != 0 && w_wr && wr_addr == rs1_addr) begin
            rs1_data = wr_data;
            rs1_busy = 1'b0;
        end
        if (BYPASS != 0 && w_wr && wr_addr == rs2_addr) begin
            rs2_data = wr_data;
            rs2_busy = 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: vector table and scoreboard bench for reg_file_sb (bypass and no-bypass)
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, wr_addr = '0, iss_rd = '0;
    logic        we = 1'b0, iss_valid = 1'b0, flush = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] rs1_data, rs2_data, b0_rs1_data, b0_rs2_data;
    logic        rs1_busy, rs2_busy, b0_rs1_busy, b0_rs2_busy;
    logic [5:0]  busy_cnt, b0_busy_cnt;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic        fl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1d;
        logic        e1b;
        logic [31:0] e2d;
        logic        e2b;
        logic [31:0] e0d;
        logic        e0b;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [20];
    vec_t q [$];

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b0_rs1_data), .rs2_data(b0_rs2_data), .rs1_busy(b0_rs1_busy), .rs2_busy(b0_rs2_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .flush(flush), .busy_cnt(b0_busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; wr_addr = '0; wr_data = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        we = v.we; wr_addr = v.wa; wr_data = v.wd; iss_valid = v.iv; iss_rd = v.ird;
        flush = v.fl; rs1_addr = v.a1; rs2_addr = v.a2;
        q.push_back(v);
        #2;
        e = q[0];
        chk($sformatf("v%0d rs1_data", idx), rs1_data, e.e1d);
        chk($sformatf("v%0d rs1_busy", idx), {31'b0, rs1_busy}, {31'b0, e.e1b});
        chk($sformatf("v%0d rs2_data", idx), rs2_data, e.e2d);
        chk($sformatf("v%0d rs2_busy", idx), {31'b0, rs2_busy}, {31'b0, e.e2b});
        chk($sformatf("v%0d nb rs1_data", idx), b0_rs1_data, e.e0d);
        chk($sformatf("v%0d nb rs1_busy", idx), {31'b0, b0_rs1_busy}, {31'b0, e.e0b});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk($sformatf("v%0d busy_cnt", idx), {26'b0, busy_cnt}, {26'b0, e.ecnt});
        chk($sformatf("v%0d nb busy_cnt", idx), {26'b0, b0_busy_cnt}, {26'b0, e.ecnt});
    endtask

    initial begin
        //            we wa  wd            iv ird fl a1  a2  e1d           e1b e2d           e2b e0d           e0b cnt
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0, 5,  0,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 0};
        tbl[1]  = '{0, 0,  32'h0,        0, 0,  0, 5,  0,  32'hDEADBEEF, 0, 32'h0,        0, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{1, 0,  32'h12345678, 0, 0,  0, 0,  0,  32'h0,        0, 32'h0,        0, 32'h0,        0, 0};
        tbl[3]  = '{0, 0,  32'h0,        0, 0,  0, 5,  0,  32'hDEADBEEF, 0, 32'h0,        0, 32'hDEADBEEF, 0, 0};
        tbl[4]  = '{1, 7,  32'hA5A5A5A5, 0, 0,  0, 7,  5,  32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0};
        tbl[5]  = '{0, 0,  32'h0,        0, 0,  0, 7,  7,  32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0};
        tbl[6]  = '{0, 0,  32'h0,        1, 3,  0, 3,  4,  32'h0,        0, 32'h0,        0, 32'h0,        0, 1};
        tbl[7]  = '{0, 0,  32'h0,        1, 4,  0, 3,  4,  32'h0,        1, 32'h0,        0, 32'h0,        1, 2};
        tbl[8]  = '{1, 3,  32'h33,       1, 4,  0, 3,  4,  32'h33,       0, 32'h0,        1, 32'h0,        1, 1};
        tbl[9]  = '{0, 0,  32'h0,        0, 0,  0, 3,  4,  32'h33,       0, 32'h0,        1, 32'h33,       0, 1};
        tbl[10] = '{0, 0,  32'h0,        0, 0,  1, 3,  4,  32'h33,       0, 32'h0,        1, 32'h33,       0, 0};
        tbl[11] = '{1, 9,  32'h11,       1, 9,  0, 9,  9,  32'h11,       0, 32'h11,       0, 32'h0,        0, 1};
        tbl[12] = '{0, 0,  32'h0,        0, 0,  0, 9,  9,  32'h11,       1, 32'h11,       1, 32'h11,       1, 1};
        tbl[13] = '{0, 0,  32'h0,        1, 10, 1, 10, 9,  32'h0,        0, 32'h11,       1, 32'h0,        0, 0};
        tbl[14] = '{0, 0,  32'h0,        0, 0,  0, 10, 9,  32'h0,        0, 32'h11,       0, 32'h0,        0, 0};
        tbl[15] = '{1, 8,  32'h88,       0, 0,  0, 8,  0,  32'h88,       0, 32'h0,        0, 32'h0,        0, 0};
        tbl[16] = '{0, 0,  32'h0,        1, 8,  0, 8,  0,  32'h88,       0, 32'h0,        0, 32'h88,       0, 1};
        tbl[17] = '{0, 0,  32'h0,        1, 8,  0, 8,  0,  32'h88,       1, 32'h0,        0, 32'h88,       1, 1};
        tbl[18] = '{1, 8,  32'h99,       0, 0,  0, 8,  0,  32'h99,       0, 32'h0,        0, 32'h88,       1, 0};
        tbl[19] = '{0, 0,  32'h0,        0, 0,  0, 8,  0,  32'h99,       0, 32'h0,        0, 32'h99,       0, 0};

        rs1_addr = 5'd5; rs2_addr = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy_cnt", {26'b0, busy_cnt}, 32'h0);
        chk("reset rs1_data", rs1_data, 32'h0);
        chk("reset rs2_busy", {31'b0, rs2_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) apply(tbl[i], i);

        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            idle();
            iss_valid = 1'b1; iss_rd = 5'(r);
            @(posedge clk);
            #1;
            chk($sformatf("fill cnt x%0d", r), {26'b0, busy_cnt}, r);
        end
        @(negedge clk);
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        #1;
        chk("fill rs2_busy x31", {31'b0, rs2_busy}, 32'h1);
        chk("fill rs1_data x5", rs1_data, 32'hDEADBEEF);
        chk("fill nb cnt", {26'b0, b0_busy_cnt}, 32'd31);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy_cnt", {26'b0, busy_cnt}, 32'h0);
        chk("midreset rs1_data", rs1_data, 32'h0);
        chk("midreset rs2_busy", {31'b0, rs2_busy}, 32'h0);

        @(negedge clk);
        we = 1'b1; wr_addr = 5'd2; wr_data = 32'h77; iss_valid = 1'b1; iss_rd = 5'd2;
        rs1_addr = 5'd2;
        #1;
        chk("inreset bypass rs1_data", rs1_data, 32'h0);
        @(posedge clk);
        #1;
        chk("inreset cnt", {26'b0, busy_cnt}, 32'h0);
        chk("inreset rs1_data", rs1_data, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk("postreset rs1_data", rs1_data, 32'h0);
        chk("postreset rs1_busy", {31'b0, rs1_busy}, 32'h0);
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd2;
        @(posedge clk);
        #1;
        chk("first edge cnt", {26'b0, busy_cnt}, 32'h1);
        chk("first edge rs1_busy", {31'b0, rs1_busy}, 32'h1);
        @(negedge clk);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers (power of two, >= 2).
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning that a same-cycle write is forwarded to the read ports.
REQ-004 The block SHALL define localparam AW = clog2(NREGS), meaning the register address width.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have ports rs1_addr and rs2_addr, input, AW bits each, meaning the read port addresses.
REQ-008 The block SHALL have ports rs1_data and rs2_data, output, XLEN bits each, meaning the read data.
REQ-009 The block SHALL have ports rs1_busy and rs2_busy, output, 1 bit each, meaning that the addressed register has a pending write.
REQ-010 The block SHALL have port we, input, 1 bit, meaning the writeback enable.
REQ-011 The block SHALL have port wr_addr, input, AW bits, meaning the writeback destination.
REQ-012 The block SHALL have port wr_data, input, XLEN bits, meaning the writeback data.
REQ-013 The block SHALL have port iss_valid, input, 1 bit, meaning an instruction with a destination register issues this cycle.
REQ-014 The block SHALL have port iss_rd, input, AW bits, meaning the destination of the issuing instruction.
REQ-015 The block SHALL have port flush, input, 1 bit, meaning clear all pending-write marks.
REQ-016 The block SHALL have port busy_cnt, output, AW+1 bits, meaning the number of registers currently marked busy.

Function
REQ-017 The block SHALL hold register 0 at constant zero: writes to it are discarded, it is never marked busy, and reads of it return 0 with busy 0.
REQ-018 The block SHALL perform writes on the clk rising edge when we=1 and wr_addr!=0: regs[wr_addr] <= wr_data, and busy[wr_addr] is cleared.
REQ-019 The block SHALL read combinationally: rsN_data = regs[rsN_addr] and rsN_busy = busy[rsN_addr].
REQ-020 The block SHALL, when BYPASS=1, we=1, wr_addr==rsN_addr and rsN_addr!=0, drive rsN_data = wr_data and rsN_busy = 0 in that same cycle.
REQ-021 The block SHALL, when BYPASS=0, return the old register value and old busy bit in the write cycle, with the new value visible on the next cycle.
REQ-022 The block SHALL, when iss_valid=1 and iss_rd!=0, set busy[iss_rd] on the next edge.
REQ-023 The block SHALL, when issue and writeback target the same register in the same cycle, leave the register busy (the issue wins) while still writing the data.
REQ-024 The block SHALL, when flush=1, clear all busy bits on the next edge; a same-cycle issue is ignored, and a same-cycle write still updates the data.
REQ-025 The block SHALL maintain busy_cnt as a registered counter equal to popcount(busy) after each edge: +1 for a set of a non-busy register, -1 for a clear of a busy register, net 0 for both or neither, and 0 on flush.
REQ-026 The block SHALL keep busy_cnt at most NREGS-1 and SHALL never let it wrap.
REQ-027 The block SHALL treat re-issue to an already-busy register as a no-op for busy_cnt.
REQ-028 The block SHALL treat a writeback to a non-busy register as a data update only.

Reset
REQ-029 The block SHALL, while rst_n=0, asynchronously clear all registers to 0, all busy bits to 0, and busy_cnt to 0, regardless of clk.
REQ-030 The block SHALL ignore an issue or write presented during reset; on deassertion, the first capturing edge is the first rising clk with rst_n=1.
REQ-031 The block SHALL, when reset is asserted mid-operation (pending busy bits present), abandon all pending writes, with all outputs reading 0 while reset is low.

Verification
REQ-032 Write x5=0xDEADBEEF, then read rs1_addr=5 next cycle -> rs1_data=0xDEADBEEF, rs1_busy=0.
REQ-033 Write x0=0x12345678, then read rs2_addr=0 -> rs2_data=0, rs2_busy=0, busy_cnt=0.
REQ-034 BYPASS=1: write x7=0xA5A5A5A5 with rs1_addr=7 in the same cycle -> rs1_data=0xA5A5A5A5 in that cycle; BYPASS=0 -> old value 0 in that cycle, 0xA5A5A5A5 the next cycle.
REQ-035 Issue x3, then x4, then issue x4 again plus writeback x3 -> busy_cnt 1, 2, 1; rs1_busy(3)=0, rs2_busy(4)=1.
REQ-036 Issue x9 and writeback x9=0x11 in the same cycle -> x9 busy=1, data=0x11, busy_cnt=1; then flush with issue x10 -> busy_cnt=0, x10 not busy.
REQ-037 Issue x1..x31 over 31 cycles -> busy_cnt=31; drop rst_n mid-clock -> busy_cnt=0 and all reads 0 immediately.
